// File: rtl/pattern_shifter_pkg.sv
// ============================================================================
// pattern_shifter_pkg : shared state and mode encodings for pattern_shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

package pattern_shifter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] ROR = 2'b01;
    localparam logic [1:0] SLL = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pattern_step.sv
// ============================================================================
// pattern_step : combinational single-bit rotate/shift of a WIDTH-bit pattern
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_step
    import pattern_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (mode)
            ROL:     dout = {din[WIDTH-2:0], din[WIDTH-1]};
            ROR:     dout = {din[0], din[WIDTH-1:1]};
            SLL:     dout = {din[WIDTH-2:0], 1'b0};
            SRL:     dout = {1'b0, din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pattern_shifter.sv
// ============================================================================
// pattern_shifter : serial barrel shifter, one bit per cycle, valid pulse out
// Revision: 1.0
// ============================================================================
`default_nettype none

module pattern_shifter
    import pattern_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SHW-1:0]   shift,
    input  logic [1:0]       mode,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] base;
    logic [SHW-1:0]   shift_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic [SHW-1:0]   cnt;
    logic [1:0]       mode_q;
    logic             trigger;

    // A changed shift amount counts as a trigger even without a load, so
    // changes that arrive while busy are picked up on the next IDLE cycle.
    assign trigger    = load_valid || (shift != shift_q);
    assign load_ready = (state == IDLE);
    assign busy       = (state == SHIFT);

    pattern_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (work),
        .mode (mode_q),
        .dout (work_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base      <= WIDTH'(1);
            shift_q   <= '0;
            work      <= '0;
            cnt       <= '0;
            mode_q    <= ROL;
            out_data  <= WIDTH'(1);
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        shift_q <= shift;
                        cnt     <= shift;
                        mode_q  <= mode;
                        work    <= load_valid ? load_data : base;
                        if (load_valid) base <= load_data;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= work_step;
                        cnt  <= cnt - SHW'(1);
                    end else begin
                        out_data  <= work;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_shifter.sv
// ============================================================================
// tb_pattern_shifter : directed and randomized checks against a result model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pattern_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SHW-1:0]   shift = '0;
    logic [1:0]       mode = 2'b00;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    pattern_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .rst        (rst),
        .shift      (shift),
        .mode       (mode),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole-operation result computed directly from the amount, not bit by bit.
    function automatic logic [7:0] ref_result(input logic [7:0] p, input int n, input logic [1:0] m);
        logic [15:0] d;
        d = {p, p};
        case (m)
            2'b00:   begin d = d << n; return d[15:8]; end
            2'b01:   begin d = d >> n; return d[7:0];  end
            2'b10:   return p << n;
            default: return p >> n;
        endcase
    endfunction

    // Model: an operation is pending for amt+1 cycles, then the result appears.
    logic [7:0] m_base, m_res, m_out;
    logic [2:0] m_shq;
    logic       m_valid;
    int         m_rem;
    int         m_loads = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_base = 8'h01; m_shq = 3'd0; m_out = 8'h01; m_valid = 1'b0; m_rem = 0;
        end else begin
            m_valid = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin m_out = m_res; m_valid = 1'b1; end
            end else if (load_valid || shift != m_shq) begin
                m_res = ref_result(load_valid ? load_data : m_base, int'(shift), mode);
                if (load_valid) begin m_base = load_data; m_loads++; end
                m_shq = shift;
                m_rem = int'(shift) + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("out_data",   out_data,   m_out);
        check("out_valid",  out_valid,  m_valid);
        check("busy",       busy,       m_rem > 0);
        check("load_ready", load_ready, m_rem == 0);
    end

    task automatic op(input bit ld, input logic [7:0] d, input logic [2:0] sh,
                      input logic [1:0] md, input logic [7:0] exp, input int lat);
        int n = 0, bcnt = 0, rdy_busy = 0;
        bit got = 0;
        @(negedge clk);
        load_valid = ld; load_data = d; shift = sh; mode = md;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            load_valid = 1'b0;
            if (busy) bcnt++;
            if (busy && load_ready) rdy_busy++;
            if (out_valid) got = 1;
        end
        check("op_done",       got, 1);
        check("op_latency",    n, lat);
        check("op_data",       out_data, exp);
        check("op_busy_cycles", bcnt, lat - 1);
        check("op_ready_while_busy", rdy_busy, 0);
    endtask

    logic [7:0] res_q[$];

    task automatic collect(input int cycles);
        res_q.delete();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) res_q.push_back(out_data);
        end
    endtask

    initial begin
        int loads0, seen, tmo;
        #12;
        check("rst_out_data",   out_data,   8'h01);
        check("rst_out_valid",  out_valid,  0);
        check("rst_busy",       busy,       0);
        check("rst_load_ready", load_ready, 1);
        @(negedge clk); rst = 1'b0;

        op(1, 8'h01, 3'd3, 2'b00, 8'h08, 5);
        op(1, 8'h81, 3'd1, 2'b01, 8'hC0, 3);
        op(0, 8'h00, 3'd2, 2'b01, 8'h60, 4);
        op(1, 8'hFF, 3'd7, 2'b10, 8'h80, 9);
        op(1, 8'hFF, 3'd7, 2'b11, 8'h01, 9);
        op(1, 8'hA5, 3'd0, 2'b00, 8'hA5, 2);

        // Load held across a busy period: accepted once when ready returns.
        loads0 = m_loads;
        @(negedge clk); shift = 3'd4; mode = 2'b00;
        @(negedge clk); load_valid = 1'b1; load_data = 8'h3C;
        tmo = 0;
        res_q.delete();
        while (!load_ready && tmo < 20) begin
            @(negedge clk); tmo++;
            if (out_valid) res_q.push_back(out_data);
        end
        check("held_load_timeout", tmo < 20, 1);
        @(negedge clk); load_valid = 1'b0;
        begin
            logic [7:0] first_res;
            first_res = (res_q.size() > 0) ? res_q[0] : 8'h00;
            check("held_first_result", first_res, 8'h5A);
        end
        collect(12);
        check("held_second_count", res_q.size(), 1);
        if (res_q.size() > 0) check("held_second_result", res_q[0], 8'hC3);
        check("held_loads_consumed", m_loads - loads0, 1);

        // Shift amount changes mid-operation.
        op(1, 8'h81, 3'd0, 2'b00, 8'h81, 2);
        @(negedge clk); shift = 3'd5;
        @(negedge clk);
        @(negedge clk); shift = 3'd6;
        res_q.delete();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) res_q.push_back(out_data);
        end
        check("midchg_pulses", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check("midchg_first",  res_q[0], 8'h30);
            check("midchg_second", res_q[1], 8'h60);
        end

        // Asynchronous reset in the middle of an operation.
        @(negedge clk); load_valid = 1'b1; load_data = 8'hF0; shift = 3'd7; mode = 2'b01;
        @(negedge clk); load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2; rst = 1'b1; shift = 3'd0;
        #1;
        check("arst_out_data",   out_data,   8'h01);
        check("arst_out_valid",  out_valid,  0);
        check("arst_busy",       busy,       0);
        check("arst_load_ready", load_ready, 1);
        @(negedge clk); rst = 1'b0;
        collect(12);
        check("post_rst_pulses", res_q.size(), 0);

        // Randomized traffic with a producer that holds loads until accepted.
        seen = m_loads;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            if (load_valid && m_loads != seen) begin
                seen = m_loads;
                load_valid = 1'b0;
            end else if (!load_valid && $urandom_range(0, 7) == 0) begin
                load_valid = 1'b1;
                load_data  = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) shift = 3'($urandom_range(0, 7));
        end
        load_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
